// File: rtl/draw_scheduler.sv
// Frame-level draw sequencer: launches each masked client in order, waits for its
// done pulse (bounded by a timeout) and forwards its pixel stream to the VGA port.
module draw_scheduler #(
    parameter int NUM_CLIENTS    = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      frame_start,
    input  logic [NUM_CLIENTS-1:0]    client_mask,
    output logic [NUM_CLIENTS-1:0]    enable_draw,
    input  logic [NUM_CLIENTS-1:0]    draw_done,
    input  logic [9*NUM_CLIENTS-1:0]  client_x,
    input  logic [8*NUM_CLIENTS-1:0]  client_y,
    input  logic [12*NUM_CLIENTS-1:0] client_color,
    input  logic [NUM_CLIENTS-1:0]    client_we,
    output logic [8:0]                vga_x,
    output logic [7:0]                vga_y,
    output logic [11:0]               vga_color,
    output logic                      vga_plot,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      timeout_err,
    output logic [7:0]                pass_count
);

    localparam int IW = $clog2(NUM_CLIENTS + 1);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CLIENTS);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_LAUNCH,
        S_WAIT,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t                  state, state_n;
    logic [IW-1:0]           idx;
    logic [NUM_CLIENTS-1:0]  mask_q;
    logic [CW-1:0]           cnt;

    logic                    sel_mask, sel_done, sel_we;
    logic [8:0]              sel_x;
    logic [7:0]              sel_y;
    logic [11:0]             sel_color;

    // Client mux keyed on idx; idx==NUM_CLIENTS selects nothing.
    always_comb begin
        sel_mask  = 1'b0;
        sel_done  = 1'b0;
        sel_we    = 1'b0;
        sel_x     = '0;
        sel_y     = '0;
        sel_color = '0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            if (idx == IW'(i)) begin
                sel_mask  = mask_q[i];
                sel_done  = draw_done[i];
                sel_we    = client_we[i];
                sel_x     = client_x[i*9 +: 9];
                sel_y     = client_y[i*8 +: 8];
                sel_color = client_color[i*12 +: 12];
            end
        end
    end

    always_comb begin
        state_n     = state;
        busy        = (state != S_IDLE);
        frame_done  = (state == S_FINISH);
        enable_draw = '0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            enable_draw[i] = (state == S_LAUNCH) && (idx == IW'(i));
        end
        case (state)
            S_IDLE:   if (frame_start) state_n = S_SELECT;
            S_SELECT: begin
                if (idx == LAST_IDX)  state_n = S_FINISH;
                else if (sel_mask)    state_n = S_LAUNCH;
            end
            S_LAUNCH: state_n = S_WAIT;
            S_WAIT:   if (sel_done || (cnt == TO_LAST)) state_n = S_NEXT;
            S_NEXT:   state_n = S_SELECT;
            S_FINISH: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_n;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx         <= '0;
            mask_q      <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
            pass_count  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        mask_q      <= client_mask;
                        idx         <= '0;
                        timeout_err <= 1'b0;
                    end
                end
                S_SELECT: if ((idx != LAST_IDX) && !sel_mask) idx <= idx + IW'(1);
                S_LAUNCH: cnt <= '0;
                S_WAIT: begin
                    cnt <= cnt + CW'(1);
                    // A done pulse on the final counted cycle beats the timeout.
                    if (!sel_done && (cnt == TO_LAST)) timeout_err <= 1'b1;
                end
                S_NEXT:   idx <= idx + IW'(1);
                S_FINISH: pass_count <= pass_count + 8'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vga_x     <= '0;
            vga_y     <= '0;
            vga_color <= '0;
            vga_plot  <= 1'b0;
        end else if ((state == S_LAUNCH) || (state == S_WAIT)) begin
            vga_x     <= sel_x;
            vga_y     <= sel_y;
            vga_color <= sel_color;
            vga_plot  <= sel_we;
        end else begin
            vga_plot  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Randomized bench for draw_scheduler: pass timing is predicted arithmetically from
// mask and client delays, pixel forwarding from the active client's write history.
module tb_draw_scheduler;

    localparam int N  = 4;
    localparam int TO = 100;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            frame_start = 1'b0;
    logic [N-1:0]    client_mask = '0;
    logic [N-1:0]    enable_draw;
    logic [N-1:0]    draw_done = '0;
    logic [9*N-1:0]  client_x = '0;
    logic [8*N-1:0]  client_y = '0;
    logic [12*N-1:0] client_color = '0;
    logic [N-1:0]    client_we = '0;
    logic [8:0]      vga_x;
    logic [7:0]      vga_y;
    logic [11:0]     vga_color;
    logic            vga_plot;
    logic            busy;
    logic            frame_done;
    logic            timeout_err;
    logic [7:0]      pass_count;

    draw_scheduler #(.NUM_CLIENTS(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn), .frame_start(frame_start), .client_mask(client_mask),
        .enable_draw(enable_draw), .draw_done(draw_done), .client_x(client_x),
        .client_y(client_y), .client_color(client_color), .client_we(client_we),
        .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .vga_plot(vga_plot),
        .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err),
        .pass_count(pass_count)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned passed = 0;

    logic [7:0]  exp_pc = '0;
    logic        exp_err = 1'b0;
    logic        exp_plot_n = 1'b0;
    logic [8:0]  exp_x_n = '0;
    logic [7:0]  exp_y_n = '0;
    logic [11:0] exp_c_n = '0;
    int          dly_q[N];
    int          obs_fd;
    logic [N-1:0] obs_en[$];
    int          obs_en_cyc[$];

    task automatic drive_pixels();
        for (int i = 0; i < N; i++) begin
            client_x[i*9 +: 9]      = 9'($urandom);
            client_y[i*8 +: 8]      = 8'($urandom);
            client_color[i*12 +: 12] = 12'($urandom);
        end
        client_we = N'($urandom);
    endtask

    // Starts at the beginning of cycle 0 (just after a rising edge); returns at the
    // beginning of cycle fd+1, which is the next pass's cycle 0.
    task automatic run_pass(input logic [N-1:0] mask, input bit drops, input bit noise);
        int en[N];
        int dn[N];
        bit to_hit[N];
        int t, fd, act;
        logic [N-1:0] exp_en;
        logic e_err;
        t = 1;
        for (int i = 0; i < N; i++) begin
            en[i] = -10; dn[i] = -10; to_hit[i] = 1'b0;
            if (mask[i]) begin
                en[i] = t + 1;
                if (dly_q[i] <= 0 || dly_q[i] > TO) begin
                    dn[i] = en[i] + TO; to_hit[i] = 1'b1;
                end else begin
                    dn[i] = en[i] + dly_q[i];
                end
                t = dn[i] + 2;
            end else begin
                t = t + 1;
            end
        end
        fd = t + 1;
        obs_fd = -1;
        obs_en.delete();
        obs_en_cyc.delete();
        for (int k = 0; k <= fd; k++) begin
            act = -1;
            for (int i = 0; i < N; i++)
                if (mask[i] && k >= en[i] && k <= dn[i]) act = i;
            frame_start = (k == 0) || (drops && $urandom_range(0, 4) == 0);
            client_mask = (k == 0) ? mask : N'($urandom);
            drive_pixels();
            for (int i = 0; i < N; i++) begin
                if (mask[i] && !to_hit[i] && k == dn[i]) draw_done[i] = 1'b1;
                else if (noise && i != act) draw_done[i] = ($urandom_range(0, 3) == 0);
                else draw_done[i] = 1'b0;
            end
            @(negedge clk);
            exp_en = '0;
            for (int i = 0; i < N; i++) if (mask[i] && k == en[i]) exp_en[i] = 1'b1;
            e_err = (k == 0) ? exp_err : 1'b0;
            for (int i = 0; i < N; i++) if (k > 0 && to_hit[i] && k > dn[i]) e_err = 1'b1;
            if (enable_draw != '0) begin obs_en.push_back(enable_draw); obs_en_cyc.push_back(k); end
            if (frame_done === 1'b1 && obs_fd < 0) obs_fd = k;

            checks++;
            if (enable_draw !== exp_en) $display("FAIL enable_draw cyc %0d: got %b want %b", k, enable_draw, exp_en);
            else passed++;
            checks++;
            if (frame_done !== (k == fd)) $display("FAIL frame_done cyc %0d: got %b want %b", k, frame_done, (k == fd));
            else passed++;
            checks++;
            if (busy !== (k != 0)) $display("FAIL busy cyc %0d: got %b want %b", k, busy, (k != 0));
            else passed++;
            checks++;
            if (timeout_err !== e_err) $display("FAIL timeout_err cyc %0d: got %b want %b", k, timeout_err, e_err);
            else passed++;
            checks++;
            if (pass_count !== exp_pc) $display("FAIL pass_count cyc %0d: got %0d want %0d", k, pass_count, exp_pc);
            else passed++;
            checks++;
            if (vga_plot !== exp_plot_n) $display("FAIL vga_plot cyc %0d: got %b want %b", k, vga_plot, exp_plot_n);
            else passed++;
            if (exp_plot_n) begin
                checks++;
                if ({vga_x, vga_y, vga_color} !== {exp_x_n, exp_y_n, exp_c_n})
                    $display("FAIL vga_pixel cyc %0d: got %h/%h/%h want %h/%h/%h",
                             k, vga_x, vga_y, vga_color, exp_x_n, exp_y_n, exp_c_n);
                else passed++;
            end
            exp_plot_n = (act >= 0) ? client_we[act] : 1'b0;
            if (exp_plot_n) begin
                exp_x_n = client_x[act*9 +: 9];
                exp_y_n = client_y[act*8 +: 8];
                exp_c_n = client_color[act*12 +: 12];
            end
            @(posedge clk); #1;
        end
        frame_start = 1'b0;
        draw_done   = '0;
        exp_pc  = exp_pc + 8'd1;
        exp_err = 1'b0;
        for (int i = 0; i < N; i++) if (to_hit[i]) exp_err = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            frame_start = 1'b0;
            drive_pixels();
            draw_done = N'($urandom);
            @(negedge clk);
            checks++;
            if ({busy, vga_plot, enable_draw} !== {1'b0, exp_plot_n, {N{1'b0}}})
                $display("FAIL idle cyc %0d: got busy=%b plot=%b en=%b", k, busy, vga_plot, enable_draw);
            else passed++;
            exp_plot_n = 1'b0;
            @(posedge clk); #1;
        end
        draw_done = '0;
    endtask

    task automatic clear_dly();
        for (int i = 0; i < N; i++) dly_q[i] = 0;
    endtask

    function automatic int rand_dly();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 0;
        if (r == 1) return TO;
        if (r == 2) return TO - 1;
        return $urandom_range(1, 15);
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        #12;
        checks++;
        if ({busy, frame_done, timeout_err, enable_draw, pass_count, vga_plot, vga_x, vga_y, vga_color} !== '0)
            $display("FAIL reset_outputs: got busy=%b fd=%b err=%b en=%b pc=%0d plot=%b", busy, frame_done,
                     timeout_err, enable_draw, pass_count, vga_plot);
        else passed++;
        #1 resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_empty_mask();
        clear_dly();
        run_pass(4'b0000, 1'b0, 1'b1);
        checks++;
        if (obs_fd !== 6) $display("FAIL empty_frame_done_cycle: got %0d want 6", obs_fd);
        else passed++;
        idle_cycles(1);
        checks++;
        if (pass_count !== 8'd1) $display("FAIL empty_pass_count: got %0d want 1", pass_count);
        else passed++;
    endtask

    task automatic test_sparse_mask();
        clear_dly();
        dly_q[0] = 70; dly_q[2] = 70;
        run_pass(4'b0101, 1'b0, 1'b1);
        checks++;
        if (obs_en.size() != 2 || obs_en[0] !== 4'b0001 || obs_en[1] !== 4'b0100 || obs_en_cyc[0] != 2)
            $display("FAIL sparse_enable_seq: got %0d pulses first=%b", obs_en.size(),
                     (obs_en.size() > 0) ? obs_en[0] : 4'b0000);
        else passed++;
    endtask

    task automatic test_timeout();
        clear_dly();
        run_pass(4'b0010, 1'b0, 1'b1);
        checks++;
        if (timeout_err !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", timeout_err);
        else passed++;
        idle_cycles(2);
        run_pass(4'b0000, 1'b0, 1'b0);
        checks++;
        if (timeout_err !== 1'b0) $display("FAIL timeout_cleared: got %b want 0", timeout_err);
        else passed++;
    endtask

    task automatic test_done_timeout_tie();
        clear_dly();
        dly_q[3] = TO;
        run_pass(4'b1000, 1'b0, 1'b1);
        dly_q[3] = TO - 1;
        run_pass(4'b1000, 1'b0, 1'b1);
    endtask

    task automatic test_busy_drop();
        clear_dly();
        dly_q[0] = 9; dly_q[2] = 4;
        run_pass(4'b0101, 1'b1, 1'b1);
        idle_cycles(3);
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 20; p++) begin
            for (int i = 0; i < N; i++) dly_q[i] = rand_dly();
            run_pass(N'($urandom), p[0], 1'b1);
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
        end
    endtask

    task automatic test_reset_mid_pass();
        frame_start = 1'b1;
        client_mask = 4'b0001;
        client_we   = 4'b0001;
        draw_done   = '0;
        @(posedge clk); #1;
        frame_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({busy, vga_plot} !== 2'b11) $display("FAIL pre_reset_plot: got busy=%b plot=%b want 1 1", busy, vga_plot);
        else passed++;
        #1 resetn = 1'b0;
        #1;
        checks++;
        if ({busy, frame_done, timeout_err, enable_draw, pass_count, vga_plot, vga_x, vga_y, vga_color} !== '0)
            $display("FAIL async_reset_outputs: got busy=%b fd=%b err=%b en=%b pc=%0d plot=%b", busy,
                     frame_done, timeout_err, enable_draw, pass_count, vga_plot);
        else passed++;
        #1 resetn = 1'b1;
        client_we = '0;
        @(posedge clk); #1;
        exp_pc = '0; exp_err = 1'b0; exp_plot_n = 1'b0;
        clear_dly();
        dly_q[0] = 5;
        run_pass(4'b0001, 1'b0, 1'b1);
        checks++;
        if (obs_en.size() != 1 || obs_en_cyc[0] != 2) $display("FAIL restart_client0: got %0d pulses", obs_en.size());
        else passed++;
    endtask

    task automatic test_wrap();
        clear_dly();
        for (int p = 0; p < 256; p++) run_pass(4'b0000, 1'b0, 1'b0);
        idle_cycles(1);
        checks++;
        if (pass_count !== 8'd1) $display("FAIL pass_count_wrap: got %0d want 1", pass_count);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_empty_mask();
        test_sparse_mask();
        test_timeout();
        test_done_timeout_tie();
        test_busy_drop();
        test_back_to_back();
        test_reset_mid_pass();
        test_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
